// File: rtl/inst_encoder_rv32_pkg.sv
// ---------------------------------------------------------------------------
// inst_encoder_rv32_pkg
// Shared ISA definitions for the RV32 instruction encoder:
//   - rv_uop micro-op enumeration and one-hot OP_*_VEC subset masks
//   - opcode / funct constants used to build R-type and I-type words
//   - canonical NOP word substituted for illegal requests
// ---------------------------------------------------------------------------
package inst_encoder_rv32_pkg;

  localparam int UOP_VEC_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_MUL  = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_JAL  = 4'd5,
    OP_JR   = 4'd6,
    OP_BNE  = 4'd7,
    OP_CSRR = 4'd8,
    OP_CSRW = 4'd9
  } rv_uop;

  localparam logic [UOP_VEC_W-1:0] OP_ADD_VEC  = UOP_VEC_W'(1) << OP_ADD;
  localparam logic [UOP_VEC_W-1:0] OP_MUL_VEC  = UOP_VEC_W'(1) << OP_MUL;
  localparam logic [UOP_VEC_W-1:0] OP_LW_VEC   = UOP_VEC_W'(1) << OP_LW;
  localparam logic [UOP_VEC_W-1:0] OP_SW_VEC   = UOP_VEC_W'(1) << OP_SW;
  localparam logic [UOP_VEC_W-1:0] OP_JAL_VEC  = UOP_VEC_W'(1) << OP_JAL;
  localparam logic [UOP_VEC_W-1:0] OP_JR_VEC   = UOP_VEC_W'(1) << OP_JR;
  localparam logic [UOP_VEC_W-1:0] OP_BNE_VEC  = UOP_VEC_W'(1) << OP_BNE;
  localparam logic [UOP_VEC_W-1:0] OP_CSRR_VEC = UOP_VEC_W'(1) << OP_CSRR;
  localparam logic [UOP_VEC_W-1:0] OP_CSRW_VEC = UOP_VEC_W'(1) << OP_CSRW;

  // TinyRV1 instruction subset
  localparam logic [UOP_VEC_W-1:0] p_tinyrv1 =
    OP_ADD_VEC | OP_MUL_VEC | OP_LW_VEC | OP_SW_VEC | OP_JAL_VEC |
    OP_JR_VEC  | OP_BNE_VEC | OP_CSRR_VEC | OP_CSRW_VEC;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_MUL     = 7'b0000001;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [2:0] F3_ADD     = 3'b000;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [UOP_VEC_W-1:0] uop_vec(input rv_uop u);
    return UOP_VEC_W'(1) << u;
  endfunction

endpackage

// File: rtl/encoder_fifo_rv32.sv
// ---------------------------------------------------------------------------
// encoder_fifo_rv32
// Val/rdy FIFO holding encoded words {inst_err, inst}.
//   clk, rst_n          : clock, asynchronous active-low reset
//   enq_val/rdy/data    : write side (full FIFO accepts when a dequeue occurs)
//   deq_val/rdy/data    : read side (data forced to 0 while empty)
// Storage is not reset; only pointers and occupancy are.
// ---------------------------------------------------------------------------
module encoder_fifo_rv32 #(
  parameter int p_depth = 2,
  parameter int p_width = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_data,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_data
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CNT_W = $clog2(p_depth + 1);

  logic [p_width-1:0] mem_q [p_depth];
  logic [p_width-1:0] mem_d [p_depth];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               enq_fire;
  logic               deq_fire;

  always_comb begin
    deq_val  = (count_q != '0);
    enq_rdy  = (count_q != CNT_W'(p_depth)) | (deq_val & deq_rdy);
    enq_fire = enq_val & enq_rdy;
    deq_fire = deq_val & deq_rdy;
    // Empty FIFO presents zeros rather than stale storage
    deq_data = deq_val ? mem_q[rd_ptr_q] : '0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) begin
      mem_d[wr_ptr_q] = enq_data;
      // Power-of-two depth: pointer wraps naturally
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_encoder_rv32.sv
// ---------------------------------------------------------------------------
// inst_encoder_rv32
// Encodes micro-op requests into RV32 instruction words and buffers them.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_val/req_rdy            : request handshake
//   req_uop/rd/rs1/rs2/imm     : micro-op fields (imm is sign-extended)
//   req_op2_sel                : 1 = immediate operand, 0 = register
//   inst_val/inst_rdy          : encoded-word handshake
//   inst, inst_err             : encoded word, 1 when it is a substituted NOP
//   err_count                  : saturating count of illegal requests taken
// Illegal requests are accepted and replaced by RV_NOP with inst_err=1.
// ---------------------------------------------------------------------------
module inst_encoder_rv32
  import inst_encoder_rv32_pkg::*;
#(
  parameter logic [UOP_VEC_W-1:0] p_isa_subset = p_tinyrv1,
  parameter int                   p_depth      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  rv_uop       req_uop,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  input  logic        req_op2_sel,
  output logic        inst_val,
  input  logic        inst_rdy,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic [7:0]  err_count
);

  logic signed [31:0] imm_s;
  logic               imm_fits;
  logic               encodable;
  logic               illegal;
  logic [31:0]        enc_word;
  logic [32:0]        enq_data;
  logic [32:0]        deq_data;
  logic               enq_fire;
  logic [7:0]         err_count_q, err_count_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Encode stage: purely combinational on the request fields
  always_comb begin
    imm_s     = req_imm;
    imm_fits  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    encodable = 1'b0;
    enc_word  = RV_NOP;
    case (req_uop)
      OP_ADD: begin
        encodable = 1'b1;
        if (req_op2_sel)
          enc_word = {req_imm[11:0], req_rs1, F3_ADD, req_rd, OPC_OP_IMM};
        else
          enc_word = {F7_ADD, req_rs2, req_rs1, F3_ADD, req_rd, OPC_OP};
      end
      OP_MUL: begin
        encodable = 1'b1;
        enc_word  = {F7_MUL, req_rs2, req_rs1, F3_ADD, req_rd, OPC_OP};
      end
      default: begin
        encodable = 1'b0;
        enc_word  = RV_NOP;
      end
    endcase
    illegal = ((p_isa_subset & uop_vec(req_uop)) == '0)
            | ((req_uop == OP_MUL) & req_op2_sel)
            | (req_op2_sel & ~imm_fits)
            | ~encodable;
    enq_data = illegal ? {1'b1, RV_NOP} : {1'b0, enc_word};
  end

  // Buffer stage: FIFO tail is written with the encoded word
  encoder_fifo_rv32 #(
    .p_depth (p_depth),
    .p_width (33)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_val  (req_val),
    .enq_rdy  (req_rdy),
    .enq_data (enq_data),
    .deq_val  (inst_val),
    .deq_rdy  (inst_rdy),
    .deq_data (deq_data)
  );

  always_comb begin
    enq_fire    = req_val & req_rdy;
    err_count_d = (enq_fire & illegal) ? sat_inc(err_count_q) : err_count_q;
    inst        = deq_data[31:0];
    inst_err    = deq_data[32];
    err_count   = err_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

endmodule
